btb_2way: RTL and testbench
===========================

Name: btb_2way

Overview:
- Branch target buffer in the fetch stage, directly upstream of the gshare predictor.
- Looks up the fetch PC combinationally in the same cycle as the PHT read.
- Produces the hit flag that drives gshare's BTB-hit input and GHR shift, plus the predicted target for next-PC selection.
- Two-way set-associative with per-set LRU replacement; updated from branch resolution.

Parameters:
- ENT_SEL, 5, index bits; number of sets = 2^ENT_SEL, indexed by pc[2+:ENT_SEL].
- PC_WIDTH, 32, PC and target width.
- TAG_WIDTH, PC_WIDTH-2-ENT_SEL, stored tag = pc[PC_WIDTH-1:2+ENT_SEL].

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- i_pc  in  PC_WIDTH  fetch PC to look up
- i_fetch_en  in  1  fetch advances this cycle; qualifies the LRU update on a hit
- o_hit  out  1  valid entry with matching tag in indexed set (combinational)
- o_target  out  PC_WIDTH  target of hitting way; 0 on miss
- i_wr_en  in  1  install/update request from branch resolution
- i_wr_pc  in  PC_WIDTH  resolved branch PC
- i_wr_target  in  PC_WIDTH  resolved target
- i_flush  in  1  invalidate all entries

Behaviour:
- Reset (async, rst_n low): all valid bits 0, all LRU bits 0. Tag/target storage is not reset. o_hit=0 and o_target=0 while valids are clear.
- Lookup is purely combinational: hit_w = valid_w[idx] & (tag_w[idx]==i_pc tag). o_hit = hit0|hit1.
  - If both ways match (illegal by construction), way0 has priority.
  - On a miss, o_target is forced to 0.
- Write (i_wr_en, applied at posedge):
  - If a valid way in set wr_idx already holds wr_tag: overwrite that way's target in place; no eviction.
  - Otherwise the victim is way0 if it is invalid, else way1 if it is invalid, else the way named by lru[wr_idx].
  - The victim gets valid=1, tag=wr_tag, target=i_wr_target.
  - After any write, lru[wr_idx] = other way (the written way becomes MRU).
- LRU on lookup: if o_hit & i_fetch_en, then lru[idx] = other way than the hit way.
  - If a write targets the same set in the same cycle, the write's LRU update wins.
  - Lookup and write to different sets update independently.
- No bypass: a lookup in the same cycle as a write sees the old contents. The new entry is visible from the next cycle.
- i_flush clears all valid bits at the next posedge. It has priority over i_wr_en and over LRU updates in that cycle; LRU bits are not cleared.
- Latency: lookup 0 cycles; write/flush effective 1 cycle later.
- Storage per set: 2x(valid, tag, target) plus 1 LRU bit.

Decomposition:
- Shared constants header: BTB_ENT_SEL, BTB_TAG_WIDTH, and the existing RV32_PC_WIDTH.
- One sub-module, btb_way (instantiated twice). It holds valid/tag/target arrays with one combinational read port and one write port. Valid bits are async-reset and have a flush input.
- Victim selection and the LRU array live in btb_2way.

Test Plan:
- Reset, then lookup i_pc=0x100 -> o_hit=0, o_target=0.
- Write 0x100->0x200. Next cycle lookup 0x100 -> o_hit=1, o_target=0x200. Lookup 0x180 (same set, different tag) -> o_hit=0.
- Fill and evict:
  - Write 0x180->0x300 (fills way1); both PCs hit.
  - Lookup 0x100 with i_fetch_en=1, so way1 becomes LRU.
  - Write 0x200->0x500, which evicts 0x180.
  - Expect: 0x100 hits 0x200, 0x200 hits 0x500, 0x180 misses.
- Rewrite 0x100->0x400 with 0x100 and 0x200 resident -> updated in place. 0x100 hits 0x400; 0x200 still hits 0x500.
- Write 0x140->0x600 while looking up 0x140 in the same cycle -> miss that cycle, hit with 0x600 the next cycle. Simultaneous lookup hit and write in the same set -> LRU equals the write's result.
- Flush with i_wr_en=1 in the same cycle -> every lookup misses the next cycle and the write is dropped. Refill, then assert rst_n low mid-cycle -> o_hit drops to 0 immediately (async).

Source files
------------

// File: rtl/btb_2way_pkg.sv
// Shared constants and way-select helpers for the two-way branch target buffer.
// The PC width matches the RV32 fetch datapath; index/tag split follows from it.
package btb_2way_pkg;

  localparam int RV32_PC_WIDTH = 32;
  localparam int BTB_ENT_SEL   = 5;
  localparam int BTB_TAG_WIDTH = RV32_PC_WIDTH - 2 - BTB_ENT_SEL;

  typedef enum logic {
    WAY0 = 1'b0,
    WAY1 = 1'b1
  } btb_way_e;

  // The LRU bit names the way to evict, so touching a way points it at the other.
  function automatic btb_way_e other_way(input btb_way_e w);
    return (w == WAY0) ? WAY1 : WAY0;
  endfunction

endpackage

// File: rtl/btb_way.sv
// One way of the BTB: per-set valid/tag/target with a combinational read port
// and a single write port that also reports tag-match status for the write set.
module btb_way
  import btb_2way_pkg::*;
#(
  parameter int ENT_SEL   = BTB_ENT_SEL,
  parameter int PC_WIDTH  = RV32_PC_WIDTH,
  parameter int TAG_WIDTH = PC_WIDTH - 2 - ENT_SEL
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_flush,
  input  logic [ENT_SEL-1:0]   i_rd_idx,
  output logic                 o_rd_valid,
  output logic [TAG_WIDTH-1:0] o_rd_tag,
  output logic [PC_WIDTH-1:0]  o_rd_target,
  input  logic                 i_wr_en,
  input  logic [ENT_SEL-1:0]   i_wr_idx,
  input  logic [TAG_WIDTH-1:0] i_wr_tag,
  input  logic [PC_WIDTH-1:0]  i_wr_target,
  output logic                 o_wr_valid,
  output logic                 o_wr_hit
);

  localparam int SETS = 1 << ENT_SEL;

  logic [SETS-1:0]      valid_q, valid_d;
  logic [TAG_WIDTH-1:0] tag_q    [SETS];
  logic [TAG_WIDTH-1:0] tag_d    [SETS];
  logic [PC_WIDTH-1:0]  target_q [SETS];
  logic [PC_WIDTH-1:0]  target_d [SETS];

  // Flush wins over a same-cycle write so nothing survives the invalidate.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (i_flush) begin
      valid_d = '0;
    end else if (i_wr_en) begin
      valid_d[i_wr_idx]  = 1'b1;
      tag_d[i_wr_idx]    = i_wr_tag;
      target_d[i_wr_idx] = i_wr_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag/target payload is qualified by valid, so it carries no reset.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

  assign o_rd_valid  = valid_q[i_rd_idx];
  assign o_rd_tag    = tag_q[i_rd_idx];
  assign o_rd_target = target_q[i_rd_idx];

  assign o_wr_valid  = valid_q[i_wr_idx];
  assign o_wr_hit    = valid_q[i_wr_idx] & (tag_q[i_wr_idx] == i_wr_tag);

endmodule

// File: rtl/btb_2way.sv
// Two-way set-associative branch target buffer with per-set LRU replacement.
// Lookup is combinational off the fetch PC; installs come from branch resolution.
module btb_2way
  import btb_2way_pkg::*;
#(
  parameter int ENT_SEL   = BTB_ENT_SEL,
  parameter int PC_WIDTH  = RV32_PC_WIDTH,
  parameter int TAG_WIDTH = PC_WIDTH - 2 - ENT_SEL
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PC_WIDTH-1:0] i_pc,
  input  logic                i_fetch_en,
  output logic                o_hit,
  output logic [PC_WIDTH-1:0] o_target,
  input  logic                i_wr_en,
  input  logic [PC_WIDTH-1:0] i_wr_pc,
  input  logic [PC_WIDTH-1:0] i_wr_target,
  input  logic                i_flush
);

  localparam int SETS = 1 << ENT_SEL;

  logic [ENT_SEL-1:0]   idx, wr_idx;
  logic [TAG_WIDTH-1:0] tag, wr_tag;

  logic [1:0]           rd_valid;
  logic [TAG_WIDTH-1:0] rd_tag    [2];
  logic [PC_WIDTH-1:0]  rd_target [2];
  logic [1:0]           wr_valid;
  logic [1:0]           wr_hit;
  logic [1:0]           way_wr_en;
  logic [1:0]           hit;
  btb_way_e             hit_way;
  btb_way_e             victim;
  logic                 wr_go;
  logic [SETS-1:0]      lru_q, lru_d;
  logic                 unused_pc_lo;

  assign idx    = i_pc[2 +: ENT_SEL];
  assign tag    = i_pc[PC_WIDTH-1 : 2+ENT_SEL];
  assign wr_idx = i_wr_pc[2 +: ENT_SEL];
  assign wr_tag = i_wr_pc[PC_WIDTH-1 : 2+ENT_SEL];

  // Instructions are word aligned; the low PC bits never select anything.
  assign unused_pc_lo = ^{i_pc[1:0], i_wr_pc[1:0]};

  btb_way #(
    .ENT_SEL  (ENT_SEL),
    .PC_WIDTH (PC_WIDTH),
    .TAG_WIDTH(TAG_WIDTH)
  ) u_way0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (i_flush),
    .i_rd_idx   (idx),
    .o_rd_valid (rd_valid[0]),
    .o_rd_tag   (rd_tag[0]),
    .o_rd_target(rd_target[0]),
    .i_wr_en    (way_wr_en[0]),
    .i_wr_idx   (wr_idx),
    .i_wr_tag   (wr_tag),
    .i_wr_target(i_wr_target),
    .o_wr_valid (wr_valid[0]),
    .o_wr_hit   (wr_hit[0])
  );

  btb_way #(
    .ENT_SEL  (ENT_SEL),
    .PC_WIDTH (PC_WIDTH),
    .TAG_WIDTH(TAG_WIDTH)
  ) u_way1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (i_flush),
    .i_rd_idx   (idx),
    .o_rd_valid (rd_valid[1]),
    .o_rd_tag   (rd_tag[1]),
    .o_rd_target(rd_target[1]),
    .i_wr_en    (way_wr_en[1]),
    .i_wr_idx   (wr_idx),
    .i_wr_tag   (wr_tag),
    .i_wr_target(i_wr_target),
    .o_wr_valid (wr_valid[1]),
    .o_wr_hit   (wr_hit[1])
  );

  // Way0 takes priority should both ways ever match.
  always_comb begin
    hit[0]   = rd_valid[0] & (rd_tag[0] == tag);
    hit[1]   = rd_valid[1] & (rd_tag[1] == tag);
    o_hit    = |hit;
    hit_way  = hit[0] ? WAY0 : WAY1;
    o_target = '0;
    if (hit[0]) begin
      o_target = rd_target[0];
    end else if (hit[1]) begin
      o_target = rd_target[1];
    end
  end

  // Update in place on a tag match, else fill an empty way, else evict LRU.
  always_comb begin
    victim = btb_way_e'(lru_q[wr_idx]);
    if (wr_hit[0]) begin
      victim = WAY0;
    end else if (wr_hit[1]) begin
      victim = WAY1;
    end else if (!wr_valid[0]) begin
      victim = WAY0;
    end else if (!wr_valid[1]) begin
      victim = WAY1;
    end
    wr_go        = i_wr_en & ~i_flush;
    way_wr_en[0] = wr_go & (victim == WAY0);
    way_wr_en[1] = wr_go & (victim == WAY1);
  end

  // The write update is applied last so it overrides a same-set lookup touch.
  always_comb begin
    lru_d = lru_q;
    if (!i_flush) begin
      if (o_hit && i_fetch_en) begin
        lru_d[idx] = other_way(hit_way);
      end
      if (i_wr_en) begin
        lru_d[wr_idx] = other_way(victim);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lru_q <= '0;
    end else begin
      lru_q <= lru_d;
    end
  end

endmodule

// File: tb/tb_btb_2way.sv
// Bench for btb_2way: a set/way table model checked every cycle at the falling
// edge, plus directed steps with literal expected hit/target values.
module tb_btb_2way;

  localparam int SETS = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_pc = '0;
  logic        i_fetch_en = 1'b0;
  logic        o_hit;
  logic [31:0] o_target;
  logic        i_wr_en = 1'b0;
  logic [31:0] i_wr_pc = '0;
  logic [31:0] i_wr_target = '0;
  logic        i_flush = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 1'b0;

  bit          m_valid [SETS][2];
  logic [31:0] m_tag   [SETS][2];
  logic [31:0] m_tgt   [SETS][2];
  int          m_lru   [SETS];

  always #5 clk = ~clk;

  btb_2way dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_pc       (i_pc),
    .i_fetch_en (i_fetch_en),
    .o_hit      (o_hit),
    .o_target   (o_target),
    .i_wr_en    (i_wr_en),
    .i_wr_pc    (i_wr_pc),
    .i_wr_target(i_wr_target),
    .i_flush    (i_flush)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int m_set(input logic [31:0] pc);
    return int'((pc / 4) % SETS);
  endfunction

  function automatic logic [31:0] m_tagof(input logic [31:0] pc);
    return pc / 128;
  endfunction

  task automatic m_lookup(input logic [31:0] pc, output bit hit, output int way,
                          output logic [31:0] tgt);
    int s;
    s   = m_set(pc);
    hit = 1'b0;
    way = 0;
    tgt = '0;
    for (int w = 1; w >= 0; w--) begin
      if (m_valid[s][w] && m_tag[s][w] == m_tagof(pc)) begin
        hit = 1'b1;
        way = w;
        tgt = m_tgt[s][w];
      end
    end
  endtask

  task automatic model_tick();
    bit          h;
    int          w;
    int          s;
    int          v;
    logic [31:0] t;
    if (!rst_n) begin
      for (int i = 0; i < SETS; i++) begin
        m_valid[i][0] = 1'b0;
        m_valid[i][1] = 1'b0;
        m_lru[i] = 0;
      end
    end else if (i_flush) begin
      for (int i = 0; i < SETS; i++) begin
        m_valid[i][0] = 1'b0;
        m_valid[i][1] = 1'b0;
      end
    end else begin
      m_lookup(i_pc, h, w, t);
      if (h && i_fetch_en) m_lru[m_set(i_pc)] = 1 - w;
      if (i_wr_en) begin
        s = m_set(i_wr_pc);
        v = -1;
        for (int k = 1; k >= 0; k--) begin
          if (m_valid[s][k] && m_tag[s][k] == m_tagof(i_wr_pc)) v = k;
        end
        if (v < 0) begin
          if (!m_valid[s][0]) v = 0;
          else if (!m_valid[s][1]) v = 1;
          else v = m_lru[s];
        end
        m_valid[s][v] = 1'b1;
        m_tag[s][v]   = m_tagof(i_wr_pc);
        m_tgt[s][v]   = i_wr_target;
        m_lru[s]      = 1 - v;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      model_tick();
    end
  end

  // Compare process: outputs are settled well before the falling edge.
  initial begin
    bit          h;
    int          w;
    logic [31:0] t;
    forever begin
      @(negedge clk);
      if (check_en && rst_n) begin
        m_lookup(i_pc, h, w, t);
        check("model_hit", {31'b0, o_hit}, {31'b0, h});
        check("model_target", o_target, t);
      end
    end
  end

  task automatic step(input logic [31:0] pc, input logic fetch, input logic wr,
                      input logic [31:0] wpc, input logic [31:0] wtgt, input logic fl);
    @(posedge clk);
    #1;
    i_pc        = pc;
    i_fetch_en  = fetch;
    i_wr_en     = wr;
    i_wr_pc     = wpc;
    i_wr_target = wtgt;
    i_flush     = fl;
  endtask

  task automatic look(input logic [31:0] pc, input logic fetch);
    step(pc, fetch, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic expect_out(input string name, input logic hit, input logic [31:0] tgt);
    #2;
    check({name, "_hit"}, {31'b0, o_hit}, {31'b0, hit});
    check({name, "_target"}, o_target, tgt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #3;
    expect_out("reset_state", 1'b0, 32'h0);
    @(posedge clk);
    #2;
    rst_n    = 1'b1;
    check_en = 1'b1;

    look(32'h100, 1'b0);                              expect_out("cold_miss", 1'b0, 32'h0);
    step(32'h100, 1'b0, 1'b1, 32'h100, 32'h200, 1'b0); expect_out("install_no_bypass", 1'b0, 32'h0);
    look(32'h100, 1'b0);                              expect_out("hit_100", 1'b1, 32'h200);
    step(32'h180, 1'b0, 1'b1, 32'h180, 32'h300, 1'b0); expect_out("tag_miss_180", 1'b0, 32'h0);
    look(32'h180, 1'b0);                              expect_out("fill_way1", 1'b1, 32'h300);
    look(32'h100, 1'b1);                              expect_out("touch_100", 1'b1, 32'h200);
    step(32'h100, 1'b0, 1'b1, 32'h200, 32'h500, 1'b0); expect_out("evict_cycle", 1'b1, 32'h200);
    look(32'h100, 1'b0);                              expect_out("kept_100", 1'b1, 32'h200);
    look(32'h200, 1'b0);                              expect_out("new_200", 1'b1, 32'h500);
    look(32'h180, 1'b0);                              expect_out("evicted_180", 1'b0, 32'h0);

    step(32'h200, 1'b0, 1'b1, 32'h100, 32'h400, 1'b0); expect_out("update_cycle", 1'b1, 32'h500);
    look(32'h100, 1'b0);                              expect_out("updated_100", 1'b1, 32'h400);
    look(32'h200, 1'b0);                              expect_out("still_200", 1'b1, 32'h500);

    step(32'h140, 1'b0, 1'b1, 32'h140, 32'h600, 1'b0); expect_out("same_cycle_140", 1'b0, 32'h0);
    look(32'h140, 1'b0);                              expect_out("next_cycle_140", 1'b1, 32'h600);

    // Lookup touches way1 while the write updates way0: write must decide LRU.
    step(32'h200, 1'b1, 1'b1, 32'h100, 32'h440, 1'b0); expect_out("lru_race", 1'b1, 32'h500);
    step(32'h300, 1'b0, 1'b1, 32'h180, 32'h700, 1'b0); expect_out("miss_300", 1'b0, 32'h0);
    look(32'h200, 1'b0);                              expect_out("race_evict_200", 1'b0, 32'h0);
    look(32'h100, 1'b0);                              expect_out("race_keep_100", 1'b1, 32'h440);
    look(32'h180, 1'b0);                              expect_out("race_new_180", 1'b1, 32'h700);

    // Lookup in set 0 and write in set 16 update their LRU bits independently.
    step(32'h100, 1'b1, 1'b1, 32'h1c0, 32'h800, 1'b0); expect_out("indep_cycle", 1'b1, 32'h440);
    step(32'h1c0, 1'b0, 1'b1, 32'h200, 32'h900, 1'b0); expect_out("hit_1c0", 1'b1, 32'h800);
    look(32'h180, 1'b0);                              expect_out("indep_evict_180", 1'b0, 32'h0);
    look(32'h100, 1'b0);                              expect_out("indep_keep_100", 1'b1, 32'h440);
    look(32'h200, 1'b0);                              expect_out("indep_new_200", 1'b1, 32'h900);
    look(32'h140, 1'b0);                              expect_out("set16_140", 1'b1, 32'h600);

    step(32'h100, 1'b1, 1'b1, 32'h240, 32'ha00, 1'b1); expect_out("flush_cycle", 1'b1, 32'h440);
    look(32'h100, 1'b0);                              expect_out("flushed_100", 1'b0, 32'h0);
    look(32'h240, 1'b0);                              expect_out("flush_drops_wr", 1'b0, 32'h0);
    look(32'h140, 1'b0);                              expect_out("flushed_140", 1'b0, 32'h0);

    step(32'h100, 1'b0, 1'b1, 32'h100, 32'hb00, 1'b0); expect_out("refill_cycle", 1'b0, 32'h0);
    look(32'h100, 1'b0);                              expect_out("refilled_100", 1'b1, 32'hb00);

    @(posedge clk);
    #2;
    check("pre_async_hit", {31'b0, o_hit}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_hit", {31'b0, o_hit}, 32'h0);
    check("async_rst_target", o_target, 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    look(32'h100, 1'b0);                              expect_out("post_reset_100", 1'b0, 32'h0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
